seq_subtractor_32bit: RTL and testbench

- Multi-cycle 32-bit subtractor with borrow in and borrow out; the inverse operation of the team's ripple-carry adders.
- Computes diff = in1 - in2 - b_in one CHUNK-bit slice per clock, LSB slice first, holding the borrow in a register between slices.
- Uses a start/busy/done handshake and reports borrow, signed-overflow and zero flags.
- Sits beside the adders in the ALU datapath and is shared by compare and subtract operations.

---
 rtl/seq_subtractor_32bit.sv | 142 ++++++++++++++
 tb/tb_seq_subtractor_32bit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor_32bit.sv
// Multi-cycle subtractor: diff = in1 - in2 - b_in, one CHUNK-bit slice per
// clock, LSB slice first. The borrow between slices lives in br_q, so the
// result is bit-identical to a single-cycle WIDTH-bit subtract. A start/busy/done
// handshake frames each operation; borrow, overflow and zero flags accompany done.
module seq_subtractor_32bit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               br_q,    br_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   diff_q,  diff_d;
  logic               b_out_q, b_out_d;
  logic               ovf_q,   ovf_d;
  logic               zero_q,  zero_d;
  logic               done_q,  done_d;

  // Operand registers viewed as arrays of slices, so the active slice is a
  // plain index by idx_q rather than a variable part-select.
  logic [CHUNK-1:0] a_slice [N];
  logic [CHUNK-1:0] b_slice [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign a_slice[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_slice[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  // One slice of the subtraction; the extra MSB is the borrow out of the slice.
  logic [CHUNK:0] sub_res;
  assign sub_res = {1'b0, a_slice[idx_q]} - {1'b0, b_slice[idx_q]} - {{CHUNK{1'b0}}, br_q};

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, flags on the last slice.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          br_d    = b_in;
          idx_d   = '0;
          diff_d  = '0;
          b_out_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            diff_d[i*CHUNK +: CHUNK] = sub_res[CHUNK-1:0];
          end
        end
        br_d  = sub_res[CHUNK];
        idx_d = idx_q + IDX_W'(1);

        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
          b_out_d = sub_res[CHUNK];
          // diff_d already carries the final slice, so flags see the complete result.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (diff_d == '0);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign diff     = diff_q;
  assign b_out    = b_out_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_subtractor_32bit.sv
// Self-checking bench for seq_subtractor_32bit: directed cases, handshake
// protocol cases, reset abort, and random operands against an arithmetic model.
module tb_seq_subtractor_32bit;

  localparam int M_NORM     = 0;  // plain operation
  localparam int M_PULSE    = 1;  // extra start pulse while running
  localparam int M_SCRAMBLE = 2;  // operands change while running
  localparam int M_HOLD     = 3;  // start stays high through the done cycle

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        b_out;
  logic        overflow;
  logic        zero;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  seq_subtractor_32bit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .b_out    (b_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic. Returns {b_out, overflow, zero, diff}.
  function automatic logic [34:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic bin);
    logic [32:0] wide;
    longint      s;
    logic        ovf;
    wide = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {wide[32], ovf, (wide[31:0] == 32'd0), wide[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check latency, busy span and results.
  // When skip_wait is set the caller is already at a negedge (back-to-back).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input string tag, input int mode, input bit skip_wait);
    logic [34:0] e;
    int          lat;
    int          bcnt;
    e = ref_sub(a, b, bin);
    if (!skip_wait) @(negedge clk);
    in1   = a;
    in2   = b;
    b_in  = bin;
    start = 1'b1;
    n_vec++;
    @(posedge clk);
    lat  = -1;
    bcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0 && mode != M_HOLD) start = 1'b0;
      if (mode == M_PULSE) begin
        if (c == 1) start = 1'b1;
        if (c == 2) start = 1'b0;
      end
      if (mode == M_SCRAMBLE && c >= 1) begin
        in1  = $urandom;
        in2  = $urandom;
        b_in = 1'($urandom_range(0, 1));
      end
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bcnt++;
    end
    $display("op %s: %h - %h - %0d -> diff=%h b_out=%0d ovf=%0d zero=%0d lat=%0d",
             tag, a, b, bin, diff, b_out, overflow, zero, lat);
    check({tag, ".latency"}, 64'(lat), 64'd4);
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'd4);
    check({tag, ".diff"}, 64'(diff), 64'(e[31:0]));
    check({tag, ".b_out"}, 64'(b_out), 64'(e[34]));
    check({tag, ".overflow"}, 64'(overflow), 64'(e[33]));
    check({tag, ".zero"}, 64'(zero), 64'(e[32]));
    if (mode != M_HOLD) begin
      @(negedge clk);
      check({tag, ".done_pulse"}, 64'(done), 64'd0);
      check({tag, ".diff_hold"}, 64'(diff), 64'(e[31:0]));
    end
  endtask

  initial begin
    bit seen_done;
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    b_in  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.flags", 64'({diff, b_out, overflow, zero}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);
    $display("reset: busy=%0d done=%0d diff=%h", busy, done, diff);

    // Directed arithmetic cases
    run_op(32'h00000005, 32'h00000003, 1'b0, "basic",      M_NORM, 1'b0);
    check("basic.const_diff", 64'(diff), 64'h2);
    run_op(32'h00000000, 32'h00000001, 1'b0, "underflow",  M_NORM, 1'b0);
    check("underflow.const_diff", 64'(diff), 64'hFFFFFFFF);
    run_op(32'h00000100, 32'h00000001, 1'b0, "xslice",     M_NORM, 1'b0);
    check("xslice.const_diff", 64'(diff), 64'hFF);
    run_op(32'h80000000, 32'h00000001, 1'b0, "ovf_neg",    M_NORM, 1'b0);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, "ovf_pos",    M_NORM, 1'b0);
    check("ovf_pos.const_flags", 64'({b_out, overflow}), 64'h3);
    run_op(32'h12345678, 32'h12345677, 1'b1, "zero_bin",   M_NORM, 1'b0);
    check("zero_bin.const_zero", 64'(zero), 64'd1);
    run_op(32'h00000000, 32'h00000000, 1'b1, "all_borrow", M_NORM, 1'b0);

    // Protocol: start ignored while busy; operands frozen at accept
    run_op(32'hDEADBEEF, 32'h01234567, 1'b1, "pulse",      M_PULSE,    1'b0);
    run_op(32'h00010000, 32'h00000001, 1'b0, "scramble",   M_SCRAMBLE, 1'b0);

    // Back-to-back: second op accepted on the done-cycle edge
    run_op(32'hCAFEF00D, 32'h0BADF00D, 1'b0, "b2b_first",  M_HOLD, 1'b0);
    run_op(32'h00000001, 32'h00000002, 1'b1, "b2b_second", M_NORM, 1'b1);

    // Reset during the third RUN cycle aborts without a done pulse
    @(negedge clk);
    in1   = 32'h11223344;
    in2   = 32'h01010101;
    b_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.outputs", 64'({diff, b_out, overflow, zero}), 64'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort.no_done", 64'(seen_done), 64'd0);
    $display("abort: busy=%0d diff=%h done_seen=%0d", busy, diff, seen_done);
    run_op(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, "post_abort", M_NORM, 1'b0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rbin;
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      if (i % 16 == 0) begin
        rb   = ra;
        rbin = 1'b0;
      end else if (i % 16 == 1) begin
        rb   = ra - 32'd1;
        rbin = 1'b1;
      end
      run_op(ra, rb, rbin, $sformatf("rnd%0d", i), M_NORM, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
